// File: rtl/micro_tile_pkg.sv
// rtl/micro_tile_pkg.sv - shared pin map and reset value for the container's micro tiles
// Purpose: ui_in/uo_out bit indices, output reset value and a status-byte packer.
// Ports: none (package).
package micro_tile_pkg;

    // ui_in bit indices
    localparam int UI_DATA_LSB = 0;
    localparam int UI_PUSH     = 4;
    localparam int UI_POP      = 5;
    localparam int UI_CLR      = 6;
    localparam int UI_VIEW     = 7;

    // uo_out bit indices
    localparam int UO_EMPTY = 4;
    localparam int UO_FULL  = 5;
    localparam int UO_OVF   = 6;
    localparam int UO_UDF   = 7;

    localparam logic [7:0] UO_RESET = 8'h10;

    // Builds the output byte using the index map above.
    function automatic logic [7:0] pack_uo(
        input logic       udf,
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [3:0] nib
    );
        logic [7:0] uo;
        uo                      = 8'h00;
        uo[UI_DATA_LSB +: 4]    = nib;
        uo[UO_EMPTY]            = empty;
        uo[UO_FULL]             = full;
        uo[UO_OVF]              = ovf;
        uo[UO_UDF]              = udf;
        return uo;
    endfunction

endpackage

// File: rtl/micro_sync_edge.sv
// rtl/micro_sync_edge.sv - multi-stage pin synchronizer with rising-edge pulse
// Purpose: pass din through SYNC_STAGES flops; flag bits that rose this cycle.
// Ports: clk, rst_n (async active-low), din[WIDTH], sync[WIDTH] (synchronized
//        level), rise[WIDTH] (one-cycle pulse on each 0->1 of sync).
module micro_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;

    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        prev_d = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;

endmodule

// File: rtl/micro_tile_nibble_fifo.sv
// rtl/micro_tile_nibble_fifo.sv - pin-driven 4-bit FIFO micro tile with sticky status
// Purpose: synchronized push/pop strobes drive a DEPTH-entry nibble FIFO; status
//          and head data (or count) are presented on a registered output byte.
// Ports: clk, rst_n (async active-low), ui_in[7:0] = {view, clr, pop, push, data[3:0]},
//        uo_out[7:0] = {udf, ovf, full, empty, head-or-count[3:0]}.
module micro_tile_nibble_fifo
    import micro_tile_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    localparam int WIDTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0] ui_s, ui_rise;

    micro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (8)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ui_in),
        .sync  (ui_s),
        .rise  (ui_rise)
    );

    logic [WIDTH-1:0] data_s;
    logic             push_p, pop_p, clr_s, view_s;
    logic             unused_rise;

    assign data_s      = ui_s[UI_DATA_LSB +: WIDTH];
    assign push_p      = ui_rise[UI_PUSH];
    assign pop_p       = ui_rise[UI_POP];
    assign clr_s       = ui_s[UI_CLR];
    assign view_s      = ui_s[UI_VIEW];
    assign unused_rise = ^{ui_rise[7:6], ui_rise[3:0]};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [7:0]       uo_out_q, uo_out_d;

    logic             full, empty, do_push, do_pop, ovf_evt, udf_evt;
    logic [WIDTH-1:0] head_d, nib_d;

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push = push_p & (~full | pop_p);
        // No fall-through: popping an empty FIFO fails even when a push lands together.
        do_pop  = pop_p & ~empty;
        ovf_evt = push_p & full & ~pop_p;
        udf_evt = pop_p & empty;

        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set beats clear so an error coinciding with clear is still reported.
        ovf_d = ovf_evt | (ovf_q & ~clr_s);
        udf_d = udf_evt | (udf_q & ~clr_s);

        // Output reflects post-commit state; forward the word being written when it
        // becomes the new head (push into an empty FIFO, or pop+push at count 1).
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = data_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        if (view_s) begin
            nib_d = 4'(count_d);
        end else if (count_d == '0) begin
            nib_d = '0;
        end else begin
            nib_d = head_d;
        end

        uo_out_d = pack_uo(udf_d, ovf_d, (count_d == DEPTH_C), (count_d == '0), nib_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            uo_out_q <= UO_RESET;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            uo_out_q <= uo_out_d;
        end
    end

    // Storage is intentionally not reset; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_s;
        end
    end

    assign uo_out = uo_out_q;

endmodule
